// File: rtl/inst_rr_scheduler.sv
// inst_rr_scheduler: round-robin owner of a shared resource among N_REQ sibling
// instances. Issues a registered one-hot grant, ends each tenure on done, request
// drop or hold limit, inserts one dead cycle, then rotates priority past the owner.
module inst_rr_scheduler #(
  parameter int unsigned N_REQ    = 5,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         done_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic                     gnt_valid_o,
  output logic [$clog2(N_REQ)-1:0] gnt_id_o,
  output logic                     timeout_pulse_o,
  output logic                     busy_o
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned HW  = $clog2(MAX_HOLD + 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDW-1:0]   LAST_IDX = IDW'(N_REQ - 1);
  localparam logic [HW-1:0]    HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   cur_q;
  logic [HW-1:0]    hold_cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic             gnt_valid_q;
  logic [IDW-1:0]   gnt_id_q;
  logic             timeout_q;
  logic             busy_q;

  logic             pick_found_c;
  logic [IDW-1:0]   pick_idx_c;
  logic             hold_max_c;
  logic             release_c;
  logic             timeout_c;
  logic [IDW-1:0]   ptr_next_c;

  // Rotated priority scan: first requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    int unsigned scan;
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan = 32'(ptr_q) + k;
      if (scan >= N_REQ) scan = scan - N_REQ;
      if (!pick_found_c && req_i[IDW'(scan)]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = IDW'(scan);
      end
    end
  end

  // Tenure end causes in priority order: done, request drop, hold limit.
  always_comb begin
    hold_max_c = (hold_cnt_q == HOLD_MAX);
    release_c  = done_i[cur_q] | ~req_i[cur_q] | hold_max_c;
    timeout_c  = ~done_i[cur_q] & req_i[cur_q] & hold_max_c;
    ptr_next_c = (cur_q == LAST_IDX) ? '0 : cur_q + IDW'(1);
  end

  // Scheduler state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cur_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_GAP: begin
          if (pick_found_c) begin
            state_q     <= S_GRANT;
            cur_q       <= pick_idx_c;
            hold_cnt_q  <= HW'(1);
            gnt_q       <= ONE_HOT0 << pick_idx_c;
            gnt_valid_q <= 1'b1;
            gnt_id_q    <= pick_idx_c;
            busy_q      <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_GRANT: begin
          if (release_c) begin
            state_q     <= S_GAP;
            ptr_q       <= ptr_next_c;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            timeout_q   <= timeout_c;
            busy_q      <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o           = gnt_q;
  assign gnt_valid_o     = gnt_valid_q;
  assign gnt_id_o        = gnt_id_q;
  assign timeout_pulse_o = timeout_q;
  assign busy_o          = busy_q;

endmodule

// File: doc/inst_rr_scheduler.md
# inst_rr_scheduler

Round-robin scheduler that shares one downstream resource (bus slot, config port or test-access channel) among the five sibling instances of a root module. Each instance raises a request; the scheduler issues a registered one-hot grant, bounds every tenure with a done handshake or a hold-limit timeout, and rotates priority so no instance starves. It sits beside the instances in the root module and is the only block allowed to drive the shared resource's select.

## Interface
- N_REQ, 5, number of requesters; legal range 2..8
- MAX_HOLD, 8, maximum grant tenure in cycles; legal range 1..255
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset; one clock, asynchronous, active-low
- req  input  N_REQ  per-instance request, level; bit i = instance i
- done  input  N_REQ  per-instance release strobe; only the bit of the granted instance is honoured
- gnt  output  N_REQ  registered one-hot grant; all-zero when no grant
- gnt_valid  output  1  OR of gnt, registered
- gnt_id  output  $clog2(N_REQ)  index of granted instance while gnt_valid, else 0
- timeout_pulse  output  1  one-cycle strobe, tenure ended by hold limit
- busy  output  1  high in GRANT and GAP states

## Operation
- State machine: IDLE, GRANT, GAP.
- Internal: ptr (priority start index, 0..N_REQ-1), hold_cnt (width $clog2(MAX_HOLD+1)), cur (granted index).
- IDLE: on a clock edge with any req bit high, pick the first set bit scanning ptr, ptr+1, ... wrapping modulo N_REQ; set gnt bit, cur, gnt_id; hold_cnt=1; go GRANT. No req: stay IDLE.
- GRANT: release is evaluated each edge; release causes, in priority order: done[cur]=1; req[cur]=0; hold_cnt==MAX_HOLD. Otherwise hold_cnt increments, gnt held.
- On release: gnt=0, gnt_valid=0, gnt_id=0, ptr=(cur+1) mod N_REQ (wrap at N_REQ-1 -> 0), go GAP. timeout_pulse=1 only if the cause was the hold limit.
- GAP: exactly one cycle, no grant; timeout_pulse cleared on leaving. At the edge leaving GAP, arbitrate as in IDLE (go GRANT directly if any req), else IDLE.
- done bits of non-granted instances and done while not in GRANT are ignored.
- A requester may re-win only after all other pending requesters with higher rotated priority are served.
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, timeout_pulse=0, busy=0, ptr=0, hold_cnt=0, state IDLE. Reset mid-grant drops gnt asynchronously; no timeout_pulse.

## Timing
- Request-to-grant latency: req high before edge k in IDLE -> gnt visible after edge k (1 cycle).
- Tenure: gnt high for T cycles, 1 <= T <= MAX_HOLD; done sampled at the edge ending cycle T drops gnt after that edge.
- Timeout: with done never asserted and req held, gnt high exactly MAX_HOLD cycles; timeout_pulse high the single GAP cycle that follows.
- Turnaround: exactly one dead cycle (GAP) between consecutive grants; back-to-back throughput one tenure per T+1 cycles.
- Simultaneous done[cur] and hold_cnt==MAX_HOLD: done wins, timeout_pulse stays 0.
- req changes on non-granted bits during GRANT have no effect until next arbitration.
- All outputs are registers; no combinational path input -> output.

## Test plan
- Single requester: req=5'b00100 held, done[2] pulsed on 3rd grant cycle -> gnt=00100 for 3 cycles, gnt_id=2, then 1 GAP cycle, re-grant to 2.
- Full rotation: req=5'b11111 held, done pulsed on 1st grant cycle each tenure -> grant order 0,1,2,3,4,0, each gnt 1 cycle separated by 1 dead cycle.
- Timeout: req[3] held, done never, MAX_HOLD=8 -> gnt[3] high 8 cycles, timeout_pulse high 1 cycle next, ptr advances to 4.
- Collision: done[cur] asserted on cycle MAX_HOLD -> release, timeout_pulse=0; req[cur] dropped mid-tenure -> release next edge, timeout_pulse=0.
- Wrap and starvation: last grant to 4, req=5'b10001 -> next grant to 0, then 4; stray done[1] during grant to 0 ignored.
- Reset mid-grant: rst_n low during GRANT to 2 -> all outputs 0 immediately; after release with req=5'b00110, first grant goes to 1 (ptr=0).
